// File: rtl/reg_file_rename.sv
// Architectural register file with a per-register rename table (busy bit + newest producer ROB tag).
// Source operands resolve combinationally to a value or, if still in flight, to a ROB lookup.
module reg_file_rename #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int REG_NUM       = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [4:0]               commit_rd,
    input  logic [31:0]              commit_val,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [4:0]               rename_rd,
    input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
    input  logic [4:0]               rs1_idx,
    output logic                     rs1_ready,
    output logic [31:0]              rs1_val,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    input  logic [4:0]               rs2_idx,
    output logic                     rs2_ready,
    output logic [31:0]              rs2_val,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
    input  logic                     rob_rs1_ready,
    input  logic [31:0]              rob_rs1_val,
    output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs2_val
);

    typedef struct packed {
        logic                     ready;
        logic [31:0]              val;
        logic [ROB_WIDTH_BIT-1:0] tag;
        logic [ROB_WIDTH_BIT-1:0] rob_id;
    } src_t;

    logic [31:0]              regs    [REG_NUM];
    logic [ROB_WIDTH_BIT-1:0] dep_tag [REG_NUM];
    logic [REG_NUM-1:0]       busy;

    // Rename is applied after commit so a same-cycle rename of the same rd keeps it busy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i]    <= '0;
                dep_tag[i] <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                busy <= '0;
                for (int i = 0; i < REG_NUM; i++) begin
                    dep_tag[i] <= '0;
                end
            end else begin
                if (commit_rd != 5'd0) begin
                    regs[commit_rd] <= commit_val;
                    if (busy[commit_rd] && dep_tag[commit_rd] == commit_rob_id) begin
                        busy[commit_rd] <= 1'b0;
                    end
                end
                if (rename_rd != 5'd0) begin
                    busy[rename_rd]    <= 1'b1;
                    dep_tag[rename_rd] <= rename_rob_id;
                end
            end
        end
    end

    function automatic src_t resolve(
        input logic [4:0]               idx,
        input logic [31:0]              reg_val,
        input logic                     is_busy,
        input logic [ROB_WIDTH_BIT-1:0] tag,
        input logic                     commit_hit,
        input logic [31:0]              bypass_val,
        input logic                     rob_ready,
        input logic [31:0]              rob_val
    );
        src_t r;
        r = '0;
        if (idx == 5'd0) begin
            r.ready = 1'b1;
        end else if (!is_busy) begin
            r.ready = 1'b1;
            r.val   = reg_val;
        end else if (commit_hit) begin
            r.ready = 1'b1;
            r.val   = bypass_val;
        end else begin
            r.ready  = rob_ready;
            r.val    = rob_ready ? rob_val : 32'd0;
            r.tag    = tag;
            r.rob_id = tag;
        end
        return r;
    endfunction

    logic commit_live;
    logic hit1;
    logic hit2;
    src_t src1;
    src_t src2;

    // The commit bypass only counts when the commit really retires the newest producer.
    always_comb begin
        commit_live = rdy_in && !clear && (commit_rd != 5'd0);
        hit1 = commit_live && (commit_rd == rs1_idx) && (dep_tag[rs1_idx] == commit_rob_id);
        hit2 = commit_live && (commit_rd == rs2_idx) && (dep_tag[rs2_idx] == commit_rob_id);
        src1 = resolve(rs1_idx, regs[rs1_idx], busy[rs1_idx], dep_tag[rs1_idx],
                       hit1, commit_val, rob_rs1_ready, rob_rs1_val);
        src2 = resolve(rs2_idx, regs[rs2_idx], busy[rs2_idx], dep_tag[rs2_idx],
                       hit2, commit_val, rob_rs2_ready, rob_rs2_val);
    end

    assign rs1_ready  = src1.ready;
    assign rs1_val    = src1.val;
    assign rs1_tag    = src1.tag;
    assign rob_rs1_id = src1.rob_id;
    assign rs2_ready  = src2.ready;
    assign rs2_val    = src2.val;
    assign rs2_tag    = src2.tag;
    assign rob_rs2_id = src2.rob_id;

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboarded random + directed bench for reg_file_rename.
module tb_reg_file_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_id;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_rob_id;
    logic [4:0]  rs1_idx;
    logic        rs1_ready;
    logic [31:0] rs1_val;
    logic [3:0]  rs1_tag;
    logic [4:0]  rs2_idx;
    logic        rs2_ready;
    logic [31:0] rs2_val;
    logic [3:0]  rs2_tag;
    logic [3:0]  rob_rs1_id;
    logic        rob_rs1_ready;
    logic [31:0] rob_rs1_val;
    logic [3:0]  rob_rs2_id;
    logic        rob_rs2_ready;
    logic [31:0] rob_rs2_val;

    reg_file_rename #(.ROB_WIDTH_BIT(4), .REG_NUM(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .rename_rd(rename_rd), .rename_rob_id(rename_rob_id),
        .rs1_idx(rs1_idx), .rs1_ready(rs1_ready), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_idx(rs2_idx), .rs2_ready(rs2_ready), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .rob_rs1_id(rob_rs1_id), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
        .rob_rs2_id(rob_rs2_id), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: value per register and the tag still owed (-1 = nothing pending).
    int unsigned m_val  [32];
    int          m_owed [32];

    // Expected entry: {ready, val, tag, rob_id}
    logic [40:0] exp_q  [$];
    int          port_q [$];
    string       name_q [$];
    string       cur_name;
    int          checks = 0;
    int          passes = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 0;
            m_owed[i] = -1;
        end
    endfunction

    function automatic logic [40:0] model_query(input logic [4:0] idx, input logic rr,
                                                input logic [31:0] rv);
        int r;
        r = int'(idx);
        if (r == 0) return {1'b1, 32'd0, 4'd0, 4'd0};
        if (m_owed[r] < 0) return {1'b1, m_val[r], 4'd0, 4'd0};
        if (rdy_in && !clear && int'(commit_rd) == r && m_owed[r] == int'(commit_rob_id))
            return {1'b1, commit_val, 4'd0, 4'd0};
        return {rr, (rr ? rv : 32'd0), m_owed[r][3:0], m_owed[r][3:0]};
    endfunction

    function automatic void model_clock();
        int c;
        int n;
        if (!rdy_in) return;
        if (clear) begin
            for (int i = 0; i < 32; i++) m_owed[i] = -1;
            return;
        end
        c = int'(commit_rd);
        n = int'(rename_rd);
        if (c != 0) begin
            m_val[c] = commit_val;
            if (m_owed[c] == int'(commit_rob_id)) m_owed[c] = -1;
        end
        if (n != 0) m_owed[n] = int'(rename_rob_id);
    endfunction

    task automatic push_expect();
        exp_q.push_back(model_query(rs1_idx, rob_rs1_ready, rob_rs1_val));
        port_q.push_back(1);
        name_q.push_back({cur_name, ".rs1"});
        exp_q.push_back(model_query(rs2_idx, rob_rs2_ready, rob_rs2_val));
        port_q.push_back(2);
        name_q.push_back({cur_name, ".rs2"});
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; clear = 1'b0;
        commit_rd = 0; commit_val = 0; commit_rob_id = 0;
        rename_rd = 0; rename_rob_id = 0;
        rs1_idx = 0; rs2_idx = 0;
        rob_rs1_ready = 0; rob_rs1_val = 0; rob_rs2_ready = 0; rob_rs2_val = 0;
    endtask

    // Called at posedge+1 with inputs already set: record expectations, then clock once.
    task automatic step(input string nm);
        cur_name = nm;
        push_expect();
        @(posedge clk_in);
        if (!rst_in) model_clock();
        #1;
        idle_inputs();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] id);
        commit_rd = rd; commit_val = v; commit_rob_id = id;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] id);
        rename_rd = rd; rename_rob_id = id;
    endtask

    task automatic do_query(input logic [4:0] i1, input logic r1, input logic [31:0] v1,
                            input logic [4:0] i2, input logic r2, input logic [31:0] v2);
        rs1_idx = i1; rob_rs1_ready = r1; rob_rs1_val = v1;
        rs2_idx = i2; rob_rs2_ready = r2; rob_rs2_val = v2;
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle against queued expectations.
    always @(negedge clk_in) begin
        logic [40:0] exp;
        logic [40:0] act;
        int          p;
        string       nm;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            p   = port_q.pop_front();
            nm  = name_q.pop_front();
            act = (p == 1) ? {rs1_ready, rs1_val, rs1_tag, rob_rs1_id}
                           : {rs2_ready, rs2_val, rs2_tag, rob_rs2_id};
            checks++;
            if (act === exp) passes++;
            else $display("FAIL %s: got ready=%0b val=%h tag=%0d rob_id=%0d, want ready=%0b val=%h tag=%0d rob_id=%0d",
                          nm, act[40], act[39:8], act[7:4], act[3:0],
                          exp[40], exp[39:8], exp[7:4], exp[3:0]);
        end
    end

    initial begin
        int owed;
        idle_inputs();
        rst_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        do_query(5'd5, 1'b0, 32'd0, 5'd0, 1'b1, 32'hDEAD);
        step("reset_q5");

        do_rename(5'd3, 4'd2);                      step("ren3_2");
        do_query(5'd3, 1'b0, 32'h0, 5'd3, 1'b1, 32'hAB);
        step("busy3");
        do_query(5'd3, 1'b1, 32'hAB, 5'd3, 1'b0, 32'h1);
        step("rob3");

        do_rename(5'd3, 4'd5);                      step("ren3_5");
        do_commit(5'd3, 32'd7, 4'd2); do_query(5'd3, 1'b0, 0, 5'd3, 1'b1, 32'h77);
        step("stale_commit3");
        do_query(5'd3, 1'b0, 0, 5'd0, 1'b0, 0);     step("still_busy3");
        do_commit(5'd3, 32'd9, 4'd5); do_query(5'd3, 1'b0, 0, 5'd3, 1'b0, 0);
        step("bypass3");
        do_query(5'd3, 1'b0, 0, 5'd3, 1'b1, 32'h5); step("free3");

        do_rename(5'd4, 4'd1);                      step("ren4_1");
        do_commit(5'd4, 32'h11, 4'd1); do_rename(5'd4, 4'd6);
        do_query(5'd4, 1'b0, 0, 5'd4, 1'b1, 32'h99);
        step("commit_rename4");
        do_query(5'd4, 1'b0, 0, 5'd4, 1'b1, 32'h42); step("busy4_6");

        do_commit(5'd7, 32'h22, 4'd0);              step("write7");
        do_rename(5'd7, 4'd3);                      step("ren7");
        do_rename(5'd10, 4'd4);                     step("ren10");
        do_rename(5'd11, 4'd5); do_query(5'd7, 1'b0, 0, 5'd10, 1'b0, 0);
        step("busy7_10");
        clear = 1'b1; do_commit(5'd7, 32'h55, 4'd3); do_rename(5'd12, 4'd1);
        do_query(5'd7, 1'b0, 0, 5'd11, 1'b0, 0);
        step("clear_cycle");
        do_query(5'd7, 1'b0, 0, 5'd11, 1'b0, 0);    step("after_clear");
        do_query(5'd10, 1'b0, 0, 5'd12, 1'b0, 0);   step("after_clear2");

        rdy_in = 1'b0; do_commit(5'd8, 32'd3, 4'd0); do_rename(5'd9, 4'd4);
        do_query(5'd8, 1'b0, 0, 5'd9, 1'b0, 0);
        step("frozen");
        do_query(5'd8, 1'b0, 0, 5'd9, 1'b0, 0);     step("after_freeze");
        do_commit(5'd0, 32'hFFFF, 4'd0); do_rename(5'd0, 4'd7);
        do_query(5'd0, 1'b0, 0, 5'd0, 1'b1, 32'h3);
        step("x0_write");
        do_query(5'd0, 1'b0, 0, 5'd0, 1'b1, 32'h3); step("x0_read");

        // Asynchronous reset mid-cycle must clear busy without a clock edge.
        do_rename(5'd13, 4'd7);                     step("ren13");
        do_query(5'd13, 1'b0, 0, 5'd4, 1'b0, 0);
        rst_in = 1'b1;
        model_reset();
        step("async_reset");
        rst_in = 1'b0;

        for (int n = 0; n < 500; n++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 19) == 0);
            commit_rd  = 5'($urandom_range(0, 7));
            commit_val = $urandom();
            owed = m_owed[commit_rd];
            commit_rob_id = (owed >= 0 && $urandom_range(0, 1) == 1) ? owed[3:0]
                                                                    : 4'($urandom_range(0, 15));
            rename_rd     = 5'($urandom_range(0, 7));
            rename_rob_id = 4'($urandom_range(0, 15));
            rs1_idx = ($urandom_range(0, 3) == 0) ? commit_rd : 5'($urandom_range(0, 7));
            rs2_idx = 5'($urandom_range(0, 7));
            rob_rs1_ready = 1'($urandom_range(0, 1)); rob_rs1_val = $urandom();
            rob_rs2_ready = 1'($urandom_range(0, 1)); rob_rs2_val = $urandom();
            step("random");
        end

        @(negedge clk_in);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
